// File: rtl/led_frame_arbiter_pkg.sv
// Shared definitions for the LED frame arbiter: FSM encoding, default sizing
// and the bit layout of the word handed to the LED matrix controller.
package led_frame_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    localparam int FRAME_WORDS = 512;
    localparam int GAP_CYCLES  = 4;

    localparam int NUM_REQ = 2;
    localparam int PIX_W   = 12;
    localparam int ADR_W   = 9;
    localparam int DOUT_W  = 32;

    localparam int DOUT_ADR_LSB = 16;
    localparam int DOUT_ADR_MSB = 24;
    localparam int DOUT_PIX_LSB = 0;
    localparam int DOUT_PIX_MSB = 11;

    // Unused bits of the output word are always zero.
    function automatic logic [DOUT_W-1:0] pack_word(input logic [ADR_W-1:0] adr,
                                                    input logic [PIX_W-1:0] pix);
        logic [DOUT_W-1:0] w;
        w = '0;
        w[DOUT_ADR_MSB:DOUT_ADR_LSB] = adr;
        w[DOUT_PIX_MSB:DOUT_PIX_LSB] = pix;
        return w;
    endfunction

endpackage

// File: rtl/led_frame_arbiter_if.sv
// Requester-side bus of the LED frame arbiter. Requesters drive the master
// modport; the arbiter sits on the slave modport.
interface led_frame_arbiter_if;
    import led_frame_arbiter_pkg::*;

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ-1:0]       valid;
    logic [NUM_REQ*PIX_W-1:0] pix;
    logic [NUM_REQ-1:0]       ready;
    logic [NUM_REQ-1:0]       gnt;
    logic [DOUT_W-1:0]        data_out;
    logic                     data_out_en;
    logic                     frame_done;
    logic                     abort;
    logic                     busy;

    modport master (
        output req, valid, pix,
        input  ready, gnt, data_out, data_out_en, frame_done, abort, busy
    );

    modport slave (
        input  req, valid, pix,
        output ready, gnt, data_out, data_out_en, frame_done, abort, busy
    );

endinterface

// File: rtl/led_rr_arb2.sv
// Two-way round-robin pick: 'pointer' names the requester that currently
// holds priority; the other one wins only when the favoured one is idle.
module led_rr_arb2 (
    input  logic [1:0] req,
    input  logic       pointer,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (pointer == 1'b0) begin
            if (req[0]) begin
                grant = 2'b01;
            end else if (req[1]) begin
                grant = 2'b10;
            end
        end else begin
            if (req[1]) begin
                grant = 2'b10;
            end else if (req[0]) begin
                grant = 2'b01;
            end
        end
    end

endmodule

// File: rtl/led_frame_arbiter.sv
// Grants whole frame loads to one of two pixel sources and streams the
// granted source's words, tagged with their address, to the LED controller.
module led_frame_arbiter #(
    parameter int FRAME_WORDS = led_frame_arbiter_pkg::FRAME_WORDS,
    parameter int GAP_CYCLES  = led_frame_arbiter_pkg::GAP_CYCLES
) (
    input logic                clk,
    input logic                reset,
    led_frame_arbiter_if.slave bus
);
    import led_frame_arbiter_pkg::*;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(FRAME_WORDS - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYCLES - 1);

    arb_state_t        state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [ADR_W-1:0]  adr_q, adr_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              ptr_q, ptr_d;
    logic [DOUT_W-1:0] dout_q, dout_d;
    logic              en_q, en_d;
    logic              done_q, done_d;
    logic              abort_q, abort_d;

    logic [1:0]        arb_grant;
    logic              xfer;
    logic              req_held;
    logic [PIX_W-1:0]  pix_sel;

    led_rr_arb2 u_rr (
        .req     (bus.req),
        .pointer (ptr_q),
        .grant   (arb_grant)
    );

    assign bus.ready = (state_q == ST_LOAD) ? gnt_q : 2'b00;
    assign xfer      = |(bus.valid & bus.ready);
    assign req_held  = |(bus.req & gnt_q);
    assign pix_sel   = gnt_q[1] ? bus.pix[2*PIX_W-1:PIX_W] : bus.pix[PIX_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            adr_q   <= '0;
            gap_q   <= '0;
            ptr_q   <= 1'b0;
            dout_q  <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            adr_q   <= adr_d;
            gap_q   <= gap_d;
            ptr_q   <= ptr_d;
            dout_q  <= dout_d;
            en_q    <= en_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    // A final transfer takes precedence over a request drop in the same
    // cycle, so a frame that completes is never reported as aborted.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        adr_d   = adr_q;
        gap_d   = gap_q;
        ptr_d   = ptr_q;
        dout_d  = dout_q;
        en_d    = 1'b0;
        done_d  = 1'b0;
        abort_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req != 2'b00) begin
                    state_d = ST_LOAD;
                    gnt_d   = arb_grant;
                    adr_d   = '0;
                    ptr_d   = arb_grant[0];
                end
            end

            ST_LOAD: begin
                if (xfer) begin
                    dout_d = pack_word(adr_q, pix_sel);
                    en_d   = 1'b1;
                    adr_d  = adr_q + 1'b1;
                end
                if (xfer && (adr_q == LAST_ADR)) begin
                    state_d = ST_GAP;
                    gnt_d   = 2'b00;
                    gap_d   = '0;
                    done_d  = 1'b1;
                end else if (!req_held) begin
                    state_d = ST_GAP;
                    gnt_d   = 2'b00;
                    gap_d   = '0;
                    abort_d = 1'b1;
                end
            end

            ST_GAP: begin
                if (gap_q == LAST_GAP) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    assign bus.gnt         = gnt_q;
    assign bus.data_out    = dout_q;
    assign bus.data_out_en = en_q;
    assign bus.frame_done  = done_q;
    assign bus.abort       = abort_q;
    assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_led_frame_arbiter.sv
// Self-checking bench for led_frame_arbiter: vector table, directed frame
// scenarios and a random run, all compared against a frame-level model.
module tb_led_frame_arbiter;
    import led_frame_arbiter_pkg::*;

    localparam int FW  = 512;
    localparam int GAP = 4;

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic [1:0]  valid;
        logic [23:0] pix;
        logic [1:0]  gnt;
        logic        en;
        logic [31:0] dout;
        logic        done;
        logic        abort;
        logic        busy;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    // Model state: who owns the current frame (-1 none), how many words of
    // it were delivered, GAP cycles still to sit out, and who has priority.
    int          m_owner = -1;
    int          m_words = 0;
    int          m_gap_left = 0;
    int          m_prio = 0;
    logic [31:0] m_dout = '0;
    logic        m_en = 1'b0;
    logic        m_done = 1'b0;
    logic        m_abort = 1'b0;

    led_frame_arbiter_if bus();

    led_frame_arbiter #(.FRAME_WORDS(FW), .GAP_CYCLES(GAP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    task automatic modelEdge();
        int o;
        m_en    = 1'b0;
        m_done  = 1'b0;
        m_abort = 1'b0;
        if (reset) begin
            m_owner    = -1;
            m_words    = 0;
            m_gap_left = 0;
            m_prio     = 0;
            m_dout     = '0;
        end else if (m_gap_left > 0) begin
            m_gap_left--;
        end else if (m_owner < 0) begin
            if (bus.req != 2'b00) begin
                o       = bus.req[m_prio] ? m_prio : 1 - m_prio;
                m_owner = o;
                m_prio  = 1 - o;
                m_words = 0;
            end
        end else begin
            o = m_owner;
            if (bus.valid[o]) begin
                m_en   = 1'b1;
                m_dout = 32'((m_words << 16) | int'(bus.pix[12*o +: 12]));
                m_words++;
            end
            if (m_words == FW) begin
                m_done     = 1'b1;
                m_owner    = -1;
                m_gap_left = GAP;
            end else if (!bus.req[o]) begin
                m_abort    = 1'b1;
                m_owner    = -1;
                m_gap_left = GAP;
            end
        end
    endtask

    function automatic logic [63:0] modelOut();
        logic [1:0] g;
        logic       b;
        g = (m_owner >= 0) ? 2'(1 << m_owner) : 2'b00;
        b = (m_owner >= 0) || (m_gap_left > 0);
        return {24'b0, g, g, b, m_en, m_done, m_abort, m_dout};
    endfunction

    function automatic logic [63:0] dutOut();
        return {24'b0, bus.gnt, bus.ready, bus.busy, bus.data_out_en,
                bus.frame_done, bus.abort, bus.data_out};
    endfunction

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("model_cycle", dutOut(), modelOut());
    endtask

    task automatic applyStimulus(input logic r, input logic [1:0] rq,
                                 input logic [1:0] v, input logic [23:0] px);
        reset     = r;
        bus.req   = rq;
        bus.valid = v;
        bus.pix   = px;
        tick();
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 2'b00, 2'b00, 24'h0);
    endtask

    task automatic feedWords(input int n, input logic [1:0] rq);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0, rq, rq, 24'($urandom));
        end
    endtask

    initial begin
        vec_t        vecs[16];
        int          strobes;
        int          sent;
        int          done_cnt;
        int          abort_cnt;
        int          gap_cycles;
        int          n_grants;
        logic        adr_ok;
        logic        words_ok;
        logic        done_last;
        logic [1:0]  prev_gnt;
        logic [1:0]  grants[3];
        logic [1:0]  rq;
        logic [1:0]  v;
        logic        r;

        vecs[0]  = '{1'b1, 2'b00, 2'b00, 24'h000000, 2'b00, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 2'b01, 2'b00, 24'h000000, 2'b01, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 2'b01, 2'b01, 24'h000111, 2'b01, 1'b1, 32'h0000_0111, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 2'b01, 2'b01, 24'h000222, 2'b01, 1'b1, 32'h0001_0222, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 2'b01, 2'b00, 24'h000999, 2'b01, 1'b0, 32'h0001_0222, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 2'b01, 2'b01, 24'h000333, 2'b01, 1'b1, 32'h0002_0333, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 2'b01, 2'b11, 24'hfff444, 2'b01, 1'b1, 32'h0003_0444, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 2'b01, 2'b01, 24'h000555, 2'b01, 1'b1, 32'h0004_0555, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 2'b01, 2'b01, 24'h000abc, 2'b01, 1'b1, 32'h0005_0abc, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 2'b00, 2'b00, 24'h000000, 2'b00, 1'b0, 32'h0005_0abc, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 2'b10, 2'b10, 24'h000000, 2'b00, 1'b0, 32'h0005_0abc, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 2'b10, 2'b10, 24'h000000, 2'b00, 1'b0, 32'h0005_0abc, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 2'b10, 2'b10, 24'h000000, 2'b00, 1'b0, 32'h0005_0abc, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 2'b10, 2'b10, 24'h000000, 2'b00, 1'b0, 32'h0005_0abc, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 2'b10, 2'b10, 24'h123000, 2'b10, 1'b0, 32'h0005_0abc, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 2'b10, 2'b10, 24'h123000, 2'b10, 1'b1, 32'h0000_0123, 1'b0, 1'b0, 1'b1};

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].valid, vecs[i].pix);
            checkOutput($sformatf("vec%0d", i), dutOut(),
                        {24'b0, vecs[i].gnt, vecs[i].gnt, vecs[i].busy, vecs[i].en,
                         vecs[i].done, vecs[i].abort, vecs[i].dout});
        end

        $display("[TB] single frame");
        doReset();
        applyStimulus(1'b0, 2'b01, 2'b01, 24'h0);
        checkOutput("single_gnt", 64'(bus.gnt), 64'(2'b01));
        strobes = 0; done_cnt = 0; done_last = 1'b0; adr_ok = 1'b1;
        for (int c = 0; c < FW + 20 && done_cnt == 0; c++) begin
            applyStimulus(1'b0, 2'b01, 2'b01, {12'h0, 12'($urandom)});
            if (bus.data_out_en) begin
                if (int'(bus.data_out[24:16]) != strobes) adr_ok = 1'b0;
                strobes++;
            end
            if (bus.frame_done) begin
                done_cnt++;
                done_last = bus.data_out_en && (strobes == FW);
            end
        end
        checkOutput("single_strobes", 64'(strobes), 64'(FW));
        checkOutput("single_adr_seq", 64'(adr_ok), 64'(1));
        checkOutput("single_done_on_last", 64'(done_last), 64'(1));
        gap_cycles = 0;
        for (int c = 0; c < GAP + 10 && bus.busy; c++) begin
            gap_cycles++;
            applyStimulus(1'b0, 2'b00, 2'b00, 24'h0);
        end
        checkOutput("single_gap_len", 64'(gap_cycles), 64'(GAP));
        checkOutput("single_idle_busy", 64'(bus.busy), 64'(0));

        $display("[TB] contention");
        doReset();
        n_grants = 0; prev_gnt = 2'b00;
        grants[0] = 2'b00; grants[1] = 2'b00; grants[2] = 2'b00;
        for (int c = 0; c < 3 * (FW + GAP + 4) && n_grants < 3; c++) begin
            applyStimulus(1'b0, 2'b11, 2'b11, 24'($urandom));
            if (bus.gnt != 2'b00 && prev_gnt == 2'b00) begin
                grants[n_grants] = bus.gnt;
                n_grants++;
            end
            prev_gnt = bus.gnt;
        end
        checkOutput("contention_count", 64'(n_grants), 64'(3));
        checkOutput("contention_frame1", 64'(grants[0]), 64'(2'b01));
        checkOutput("contention_frame2", 64'(grants[1]), 64'(2'b10));
        checkOutput("contention_frame3", 64'(grants[2]), 64'(2'b01));

        $display("[TB] stall");
        doReset();
        applyStimulus(1'b0, 2'b01, 2'b00, 24'h0);
        strobes = 0; sent = 0; words_ok = 1'b1; done_cnt = 0;
        for (int c = 0; c < 2 * FW + 20 && done_cnt == 0; c++) begin
            if (c % 2 == 0) begin
                applyStimulus(1'b0, 2'b01, 2'b01, {12'h0, 12'(sent * 7 + 3)});
                sent++;
            end else begin
                applyStimulus(1'b0, 2'b01, 2'b00, 24'h000fff);
            end
            if (bus.data_out_en) begin
                if (bus.data_out !== 32'((strobes << 16) | ((strobes * 7 + 3) & 'hfff)))
                    words_ok = 1'b0;
                strobes++;
            end
            if (bus.frame_done) done_cnt++;
        end
        checkOutput("stall_strobes", 64'(strobes), 64'(FW));
        checkOutput("stall_words", 64'(words_ok), 64'(1));
        checkOutput("stall_done", 64'(done_cnt), 64'(1));

        $display("[TB] abort");
        doReset();
        applyStimulus(1'b0, 2'b01, 2'b01, 24'h0);
        feedWords(100, 2'b01);
        applyStimulus(1'b0, 2'b00, 2'b00, 24'h0);
        checkOutput("abort_pulse", 64'(bus.abort), 64'(1));
        checkOutput("abort_no_done", 64'(bus.frame_done), 64'(0));
        checkOutput("abort_gnt", 64'(bus.gnt), 64'(0));
        abort_cnt = 0; done_cnt = 0;
        for (int c = 0; c < GAP + 2; c++) begin
            applyStimulus(1'b0, 2'b00, 2'b00, 24'h0);
            abort_cnt += int'(bus.abort);
            done_cnt  += int'(bus.frame_done);
        end
        checkOutput("abort_single_pulse", 64'(abort_cnt), 64'(0));
        checkOutput("abort_quiet_done", 64'(done_cnt), 64'(0));
        applyStimulus(1'b0, 2'b01, 2'b01, 24'h0);
        applyStimulus(1'b0, 2'b01, 2'b01, 24'h0005a5);
        checkOutput("abort_restart_adr", 64'(bus.data_out), 64'(32'h0000_05a5));

        $display("[TB] drop on final word");
        doReset();
        applyStimulus(1'b0, 2'b01, 2'b01, 24'h0);
        feedWords(FW - 1, 2'b01);
        applyStimulus(1'b0, 2'b00, 2'b01, 24'h0007e7);
        checkOutput("edge_done", 64'(bus.frame_done), 64'(1));
        checkOutput("edge_abort", 64'(bus.abort), 64'(0));
        checkOutput("edge_last_word", 64'(bus.data_out), 64'(32'h01ff_07e7));
        abort_cnt = 0;
        for (int c = 0; c < GAP + 2; c++) begin
            applyStimulus(1'b0, 2'b00, 2'b00, 24'h0);
            abort_cnt += int'(bus.abort);
        end
        checkOutput("edge_no_late_abort", 64'(abort_cnt), 64'(0));

        $display("[TB] reset mid-load");
        doReset();
        applyStimulus(1'b0, 2'b01, 2'b01, 24'h0);
        feedWords(300, 2'b01);
        applyStimulus(1'b1, 2'b01, 2'b01, 24'($urandom));
        checkOutput("reset_mid_load", dutOut(), 64'h0);
        abort_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 2'b00, 2'b00, 24'h0);
            abort_cnt += int'(bus.abort);
            done_cnt  += int'(bus.frame_done);
        end
        checkOutput("reset_no_pulses", 64'(abort_cnt + done_cnt), 64'(0));

        $display("[TB] random traffic");
        doReset();
        rq = 2'b11;
        for (int c = 0; c < 6000; c++) begin
            for (int b = 0; b < 2; b++) begin
                if ($urandom_range(0, 599) == 0) rq[b] = ~rq[b];
                v[b] = ($urandom_range(0, 3) != 0);
            end
            r = ($urandom_range(0, 2999) == 0);
            applyStimulus(r, rq, v, 24'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/led_frame_arbiter.md
LED_FRAME_ARBITER -- requirements
Module: led_frame_arbiter

Interface
REQ-001 Parameters SHALL be: FRAME_WORDS, default 512, words per frame load; GAP_CYCLES, default 4, idle cycles between frame loads.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  2  per-requester frame-load request, level, bit i = requester i.
REQ-005 valid  input  2  per-requester pixel word valid.
REQ-006 pix  input  24  pixel payloads; requester i drives bits [12i+11:12i].
REQ-007 ready  output  2  per-requester pixel word accepted this cycle.
REQ-008 gnt  output  2  one-hot frame grant, or zero.
REQ-009 data_out  output  32  word to LED matrix controller.
REQ-010 data_out_en  output  1  single-cycle strobe qualifying data_out.
REQ-011 frame_done  output  1  single-cycle pulse: full frame delivered.
REQ-012 abort  output  1  single-cycle pulse: frame terminated early.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD and GAP.
REQ-015 IDLE: if req != 0, the next state SHALL be LOAD; gnt SHALL be set one-hot to the winner; the word address SHALL be cleared to 0.
REQ-016 Arbitration SHALL be round-robin: the requester granted last has lowest priority; after reset requester 0 has priority.
REQ-017 A grant SHALL be frame-atomic: gnt SHALL NOT change during LOAD.
REQ-018 ready[i] SHALL equal (state==LOAD && gnt[i]); a transfer SHALL occur when valid[i] && ready[i].
REQ-019 Each transfer SHALL register data_out = {7'b0, adr[8:0], 4'b0, pix_i[11:0]} with data_out_en=1 on the following cycle (latency 1).
REQ-020 data_out_en SHALL be 0 in every cycle not immediately following a transfer; data_out SHALL hold its last value otherwise.
REQ-021 The address SHALL increment by 1 per transfer, 9-bit, with no wrap inside a frame.
REQ-022 A transfer at adr == FRAME_WORDS-1 SHALL go to GAP, clear gnt, and pulse frame_done one cycle later, coincident with the last data_out_en.
REQ-023 If req[g] deasserts in LOAD with no final transfer, the FSM SHALL go to GAP, clear gnt, pulse abort once, and SHALL NOT pulse frame_done.
REQ-024 If req[g] deasserts in the same cycle as the final transfer, the transfer SHALL complete, frame_done SHALL pulse, and abort SHALL NOT pulse.
REQ-025 valid gaps during LOAD SHALL stall the address without timeout.
REQ-026 GAP SHALL last exactly GAP_CYCLES cycles, then return to IDLE; requests SHALL be ignored during GAP.
REQ-027 The round-robin pointer SHALL update on grant, including grants that later abort.

Reset
REQ-028 On reset the following SHALL hold: state=IDLE, gnt=0, ready=0, adr=0, data_out=0, data_out_en=0, frame_done=0, abort=0, busy=0, pointer=requester 0 priority.
REQ-029 Reset mid-LOAD SHALL drop the frame without a frame_done or abort pulse.

Structure
REQ-030 A shared package SHALL define the FSM state encoding, the constants FRAME_WORDS and GAP_CYCLES, and the data_out field positions (address [24:16], pixel [11:0]).
REQ-031 The round-robin arbiter SHALL be a sub-module named led_rr_arb2, with inputs req[1:0] and pointer and output grant[1:0].

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- Single frame: req=01 with valid held high -> gnt=01 next cycle; 512 data_out_en strobes carrying adr 0..511; frame_done on the last strobe; 4 GAP cycles; busy=0 afterwards.
- Contention: req=11 held after reset -> requester 0 gets frame 1, requester 1 gets frame 2, requester 0 gets frame 3.
- Data format: pix_0=12'hABC at adr 5 -> data_out=32'h0005_0ABC.
- Stall: valid toggles at 50% duty -> exactly 512 strobes, address continuous, no dropped or duplicated words.
- Abort: req[0] drops at adr 100 -> abort pulses once, no frame_done, gnt=0; the next grant starts at adr 0.
- Edge cases: req drop coincident with the adr-511 transfer -> frame_done=1 and abort=0; reset at adr 300 -> all outputs return to the REQ-028 values the next cycle.
